// File: rtl/dtw_seq_loader.sv
// dtw_seq_loader: captures the R sequence from the input stream, buffers it
// through a small FIFO while the shared memory port is contended, writes it
// to R_BASE.., then kicks the DTW core and waits for it to finish.
module dtw_seq_loader #(
    parameter int SEQ_LEN    = 20,
    parameter int R_BASE     = 'h3C0,
    parameter int FIFO_DEPTH = 4,
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 10
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic [DATA_W-1:0] dtw_in,
    input  logic              dtw_valid,
    output logic              mem_req,
    input  logic              mem_gnt,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_WR,
    output logic              mem_CS,
    output logic              start,
    input  logic              core_done,
    output logic              busy,
    output logic              err_short,
    output logic              err_ovf
);

    localparam int CNT_W = $clog2(SEQ_LEN + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        FLUSH,
        START,
        WAIT_CORE
    } state_t;

    state_t state, state_nxt;

    // FIFO pointers carry one extra bit so full and empty are distinguishable.
    logic [PTR_W:0]    wr_ptr, rd_ptr, fifo_occ;
    logic              fifo_empty, fifo_full;
    logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
    // Each entry remembers its slot so a dropped word leaves a hole instead
    // of shifting every later word down one address.
    logic [CNT_W-1:0]  fifo_slot [FIFO_DEPTH];

    logic [CNT_W-1:0]  in_cnt;   // words accepted (including dropped ones)
    logic [CNT_W-1:0]  wr_idx;   // slots resolved (written or dropped)

    logic accept, push, pop, drop, clear, set_short, set_ovf;

    function automatic logic [ADDR_W-1:0] slot_addr(input logic [CNT_W-1:0] slot);
        return ADDR_W'(R_BASE) + ADDR_W'(slot);
    endfunction

    assign fifo_occ   = wr_ptr - rd_ptr;
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (fifo_occ == (PTR_W + 1)'(FIFO_DEPTH));
    assign busy       = (state != IDLE);

    // State register.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic plus the FIFO push/pop and error strobes.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        pop       = 1'b0;
        clear     = 1'b0;
        set_short = 1'b0;
        set_ovf   = 1'b0;
        start     = 1'b0;
        mem_req   = 1'b0;
        case (state)
            IDLE: begin
                if (dtw_valid) begin
                    accept    = 1'b1;
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                mem_req = !fifo_empty;
                if (dtw_valid) begin
                    accept = 1'b1;
                    pop    = !fifo_empty && mem_gnt;
                    if (in_cnt == CNT_W'(SEQ_LEN - 1)) begin
                        state_nxt = FLUSH;
                    end
                end else begin
                    // Stream broke mid-sequence: abandon the load without
                    // issuing this cycle's write.
                    set_short = 1'b1;
                    clear     = 1'b1;
                    state_nxt = IDLE;
                end
            end
            FLUSH: begin
                mem_req = !fifo_empty;
                pop     = !fifo_empty && mem_gnt;
                set_ovf = dtw_valid;
                if (wr_idx == CNT_W'(SEQ_LEN)) begin
                    state_nxt = START;
                end
            end
            START: begin
                start     = 1'b1;
                set_ovf   = dtw_valid;
                state_nxt = WAIT_CORE;
            end
            WAIT_CORE: begin
                set_ovf = dtw_valid;
                if (core_done) begin
                    clear     = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                clear     = 1'b1;
                state_nxt = IDLE;
            end
        endcase
        // A full FIFO can still take a word when one leaves in the same cycle.
        push = accept && (!fifo_full || pop);
        drop = accept && fifo_full && !pop;
        if (drop) begin
            set_ovf = 1'b1;
        end
    end

    // FIFO pointers and sequence counters.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            in_cnt <= '0;
            wr_idx <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            in_cnt <= '0;
            wr_idx <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (PTR_W + 1)'(1);
            if (pop) rd_ptr <= rd_ptr + (PTR_W + 1)'(1);
            if (accept) in_cnt <= in_cnt + CNT_W'(1);
            if (pop || drop) wr_idx <= wr_idx + CNT_W'(1);
        end
    end

    // FIFO storage; contents are meaningful only between the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr[PTR_W-1:0]] <= dtw_in;
            fifo_slot[wr_ptr[PTR_W-1:0]] <= in_cnt;
        end
    end

    // Memory write stage: a popped word is presented for exactly one cycle.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            mem_CS   <= 1'b1;
            mem_WR   <= 1'b0;
            mem_addr <= '0;
            mem_data <= '0;
        end else if (pop) begin
            mem_CS   <= 1'b0;
            mem_WR   <= 1'b1;
            mem_addr <= slot_addr(fifo_slot[rd_ptr[PTR_W-1:0]]);
            mem_data <= fifo_data[rd_ptr[PTR_W-1:0]];
        end else begin
            mem_CS <= 1'b1;
            mem_WR <= 1'b0;
        end
    end

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            err_short <= 1'b0;
            err_ovf   <= 1'b0;
        end else begin
            if (set_short) err_short <= 1'b1;
            if (set_ovf) err_ovf <= 1'b1;
        end
    end

endmodule

// File: tb/tb_dtw_seq_loader.sv
// Testbench for dtw_seq_loader: randomized loads under various grant
// patterns, checked against a queue-based model of the input buffer.
module tb_dtw_seq_loader;

    localparam int SEQ   = 20;
    localparam int DEPTH = 4;
    localparam logic [9:0] RB = 10'h3C0;

    logic        clk;
    logic        nrst;
    logic [31:0] dtw_in;
    logic        dtw_valid;
    logic        mem_req;
    logic        mem_gnt;
    logic [9:0]  mem_addr;
    logic [31:0] mem_data;
    logic        mem_WR;
    logic        mem_CS;
    logic        start;
    logic        core_done;
    logic        busy;
    logic        err_short;
    logic        err_ovf;

    dtw_seq_loader dut (
        .clk(clk), .nrst(nrst), .dtw_in(dtw_in), .dtw_valid(dtw_valid),
        .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_addr(mem_addr),
        .mem_data(mem_data), .mem_WR(mem_WR), .mem_CS(mem_CS),
        .start(start), .core_done(core_done), .busy(busy),
        .err_short(err_short), .err_ovf(err_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // model state
    bit          gnt_pat [0:127];
    logic [31:0] words [0:SEQ-1];
    logic [31:0] exp_mem [0:1023];
    logic [31:0] dut_mem [0:1023];
    int          exp_slots[$];
    bit          m_ovf, m_short;

    // write / start monitor, sampled on the falling edge
    int          cyc = 0;
    int          start_cnt, start_wide, wr_bad, last_wr_cyc, start_cyc;
    logic        start_prev = 1'b0;
    logic [9:0]  wa_q[$];
    logic [31:0] wd_q[$];

    always @(negedge clk) begin
        cyc++;
        if (mem_CS === 1'b0) begin
            if (mem_WR !== 1'b1) wr_bad++;
            wa_q.push_back(mem_addr);
            wd_q.push_back(mem_data);
            dut_mem[mem_addr] = mem_data;
            last_wr_cyc = cyc;
        end
        if (start === 1'b1) begin
            start_cnt++;
            start_cyc = cyc;
            if (start_prev === 1'b1) start_wide++;
        end
        start_prev = start;
    end

    function automatic bit gnt_at(input int c);
        return (c < 128) ? gnt_pat[c] : 1'b1;
    endfunction

    task automatic clear_mon();
        wa_q.delete();
        wd_q.delete();
        start_cnt = 0; start_wide = 0; wr_bad = 0;
        last_wr_cyc = 0; start_cyc = 0;
    endtask

    task automatic gnt_all_ones();
        for (int i = 0; i < 128; i++) gnt_pat[i] = 1'b1;
    endtask

    task automatic apply_reset();
        nrst = 1'b0; dtw_valid = 1'b0; core_done = 1'b0; mem_gnt = 1'b0;
        repeat (2) @(posedge clk);
        #1 nrst = 1'b1;
        m_ovf = 1'b0; m_short = 1'b0;
    endtask

    // Drive one load of n_words and compare the resulting writes to the model.
    task automatic do_load(input int n_words, input bit fixed_data, input string tag);
        int q[$];
        int drops;
        int t;
        int bad_img;
        bit full_seq;
        full_seq = (n_words == SEQ);
        for (int i = 0; i < SEQ; i++) words[i] = fixed_data ? 32'h100 + i : $urandom();
        // Model: each cycle a queued word leaves if granted, then the new
        // word joins unless the buffer is still full.
        exp_slots.delete();
        drops = 0;
        for (int c = 0; c < 200; c++) begin
            bit p;
            if (!full_seq && c >= n_words) break;
            if (full_seq && c >= n_words && q.size() == 0) break;
            p = (q.size() > 0) && gnt_at(c);
            if (p) exp_slots.push_back(q.pop_front());
            if (c < n_words) begin
                if (q.size() == DEPTH) drops++;
                else q.push_back(c);
            end
        end
        if (drops > 0) m_ovf = 1'b1;
        if (!full_seq) m_short = 1'b1;

        clear_mon();
        t = 0;
        while (t < (full_seq ? 200 : n_words + 4)) begin
            dtw_valid = (t < n_words);
            dtw_in    = (t < n_words) ? words[t] : $urandom();
            mem_gnt   = gnt_at(t);
            @(posedge clk);
            #1;
            t++;
            if (full_seq && start_cnt > 0) break;
        end
        dtw_valid = 1'b0;
        mem_gnt   = 1'b1;

        if (full_seq) begin
            checks++;
            if (start_cnt == 0) begin
                errors++;
                $display("FAIL %s start_timeout: got no start after %0d cycles, need one", tag, t);
            end
        end
        checks++;
        if (wa_q.size() != exp_slots.size()) begin
            errors++;
            $display("FAIL %s write_count: got %0d need %0d", tag, wa_q.size(), exp_slots.size());
        end
        for (int i = 0; i < exp_slots.size() && i < wa_q.size(); i++) begin
            checks++;
            if (wa_q[i] !== RB + 10'(exp_slots[i]) || wd_q[i] !== words[exp_slots[i]]) begin
                errors++;
                $display("FAIL %s write_%0d: got addr %h data %h need addr %h data %h",
                         tag, i, wa_q[i], wd_q[i], RB + 10'(exp_slots[i]), words[exp_slots[i]]);
            end
            exp_mem[RB + 10'(exp_slots[i])] = words[exp_slots[i]];
        end
        bad_img = 0;
        for (int a = 0; a < SEQ; a++) if (dut_mem[RB + 10'(a)] !== exp_mem[RB + 10'(a)]) bad_img++;
        checks++;
        if (bad_img != 0) begin
            errors++;
            $display("FAIL %s mem_image: got %0d wrong words need 0", tag, bad_img);
        end
        checks++;
        if (wr_bad != 0) begin
            errors++;
            $display("FAIL %s write_strobe: got %0d CS-low cycles without WR need 0", tag, wr_bad);
        end
        checks++;
        if (start_cnt != (full_seq ? 1 : 0) || start_wide != 0) begin
            errors++;
            $display("FAIL %s start_pulse: got count %0d wide %0d need count %0d wide 0",
                     tag, start_cnt, start_wide, full_seq ? 1 : 0);
        end
        if (full_seq && exp_slots.size() > 0) begin
            checks++;
            if (start_cyc <= last_wr_cyc) begin
                errors++;
                $display("FAIL %s start_order: got start cyc %0d last write cyc %0d need start later",
                         tag, start_cyc, last_wr_cyc);
            end
        end
        checks++;
        if (err_ovf !== m_ovf || err_short !== m_short) begin
            errors++;
            $display("FAIL %s err_flags: got ovf %b short %b need ovf %b short %b",
                     tag, err_ovf, err_short, m_ovf, m_short);
        end
        checks++;
        if (busy !== full_seq) begin
            errors++;
            $display("FAIL %s busy_after_load: got %b need %b", tag, busy, full_seq);
        end
    endtask

    // Hold off a few cycles, then release the core and expect busy to drop.
    task automatic finish_core(input string tag);
        int sc;
        sc = start_cnt;
        repeat (3) begin @(posedge clk); #1; end
        checks++;
        if (busy !== 1'b1 || start_cnt != sc) begin
            errors++;
            $display("FAIL %s wait_hold: got busy %b starts %0d need busy 1 starts %0d", tag, busy, start_cnt, sc);
        end
        core_done = 1'b1;
        @(posedge clk); #1;
        core_done = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s done_release: got busy %b need 0", tag, busy);
        end
    endtask

    task automatic test_reset();
        nrst = 1'b0; dtw_valid = 1'b0; core_done = 1'b0; mem_gnt = 1'b0; dtw_in = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (mem_CS !== 1'b1 || mem_WR !== 1'b0 || mem_req !== 1'b0 || mem_addr !== 10'h0 ||
            mem_data !== 32'h0 || start !== 1'b0 || busy !== 1'b0 || err_short !== 1'b0 || err_ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: got CS %b WR %b req %b addr %h data %h start %b busy %b es %b eo %b need 1 0 0 000 00000000 0 0 0 0",
                     mem_CS, mem_WR, mem_req, mem_addr, mem_data, start, busy, err_short, err_ovf);
        end
        nrst = 1'b1;
        m_ovf = 1'b0; m_short = 1'b0;
    endtask

    task automatic test_idle_noise();
        int busy_hi;
        busy_hi = 0;
        clear_mon();
        for (int i = 0; i < 30; i++) begin
            dtw_valid = 1'b0;
            dtw_in    = $urandom();
            mem_gnt   = $urandom_range(0, 1);
            core_done = $urandom_range(0, 1);
            @(posedge clk); #1;
            if (busy !== 1'b0 || mem_req !== 1'b0) busy_hi++;
        end
        core_done = 1'b0;
        checks++;
        if (wa_q.size() != 0 || start_cnt != 0 || busy_hi != 0) begin
            errors++;
            $display("FAIL idle_noise: got writes %0d starts %0d busy/req cycles %0d need 0 0 0",
                     wa_q.size(), start_cnt, busy_hi);
        end
    endtask

    task automatic test_contiguous();
        gnt_all_ones();
        do_load(SEQ, 1'b1, "contiguous");
        finish_core("contiguous");
    endtask

    task automatic test_gnt_gap3();
        gnt_all_ones();
        for (int i = 3; i <= 5; i++) gnt_pat[i] = 1'b0;
        do_load(SEQ, 1'b1, "gap3");
        checks++;
        if (err_ovf !== 1'b0) begin
            errors++;
            $display("FAIL gap3_no_ovf: got err_ovf %b need 0", err_ovf);
        end
        finish_core("gap3");
    endtask

    task automatic test_gnt_gap6();
        gnt_all_ones();
        for (int i = 3; i <= 8; i++) gnt_pat[i] = 1'b0;
        do_load(SEQ, 1'b0, "gap6");
        checks++;
        if (err_ovf !== 1'b1) begin
            errors++;
            $display("FAIL gap6_ovf: got err_ovf %b need 1", err_ovf);
        end
        finish_core("gap6");
    endtask

    task automatic test_wait_valid();
        int sc;
        apply_reset();
        gnt_all_ones();
        do_load(SEQ, 1'b0, "waitvalid");
        sc = start_cnt;
        wa_q.delete();
        wd_q.delete();
        for (int i = 0; i < 2; i++) begin
            dtw_valid = 1'b1; dtw_in = $urandom();
            @(posedge clk); #1;
        end
        dtw_valid = 1'b0;
        checks++;
        if (err_ovf !== 1'b1 || wa_q.size() != 0 || busy !== 1'b1 || start_cnt != sc) begin
            errors++;
            $display("FAIL wait_valid: got ovf %b writes %0d busy %b starts %0d need 1 0 1 %0d",
                     err_ovf, wa_q.size(), busy, start_cnt, sc);
        end
        m_ovf = 1'b1;
        finish_core("waitvalid");
    endtask

    task automatic test_short();
        apply_reset();
        gnt_all_ones();
        do_load(7, 1'b0, "short");
        checks++;
        if (err_short !== 1'b1 || wa_q.size() > 7) begin
            errors++;
            $display("FAIL short_abort: got err_short %b writes %0d need 1 and at most 7", err_short, wa_q.size());
        end
        do_load(SEQ, 1'b0, "after_short");
        finish_core("after_short");
    endtask

    task automatic test_reset_mid();
        apply_reset();
        gnt_all_ones();
        clear_mon();
        for (int t = 0; t < 9; t++) begin
            dtw_valid = 1'b1; dtw_in = $urandom(); mem_gnt = 1'b1;
            @(posedge clk); #1;
        end
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL resetmid_loading: got busy %b need 1", busy);
        end
        dtw_valid = 1'b1; dtw_in = $urandom();
        #2 nrst = 1'b0;
        #1;
        checks++;
        if (mem_CS !== 1'b1 || mem_WR !== 1'b0 || mem_req !== 1'b0 || mem_addr !== 10'h0 ||
            mem_data !== 32'h0 || start !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL resetmid_async: got CS %b WR %b req %b addr %h data %h start %b busy %b need 1 0 0 000 00000000 0 0",
                     mem_CS, mem_WR, mem_req, mem_addr, mem_data, start, busy);
        end
        dtw_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 nrst = 1'b1;
        m_ovf = 1'b0; m_short = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        checks++;
        if (start_cnt != 0) begin
            errors++;
            $display("FAIL resetmid_nostart: got %0d starts need 0", start_cnt);
        end
        do_load(SEQ, 1'b0, "after_resetmid");
        finish_core("after_resetmid");
    endtask

    task automatic test_random();
        for (int r = 0; r < 4; r++) begin
            apply_reset();
            for (int i = 0; i < 128; i++) gnt_pat[i] = ($urandom_range(0, 3) != 0);
            do_load(SEQ, 1'b0, "random");
            finish_core("random");
        end
    endtask

    initial begin
        for (int a = 0; a < 1024; a++) begin
            exp_mem[a] = 32'h0;
            dut_mem[a] = 32'h0;
        end
        gnt_all_ones();
        clear_mon();
        test_reset();
        test_idle_noise();
        test_contiguous();
        test_gnt_gap3();
        test_gnt_gap6();
        test_wait_valid();
        test_short();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
